// File: rtl/draw_pkg.sv
// ============================================================================
// Module   : draw_pkg
// Purpose  : Shared scheduler state encodings, the framebuffer address-width
//            helper and the drawer write-port data width.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package draw_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_CLEAR_START = 3'd1,
        ST_CLEAR_WAIT  = 3'd2,
        ST_PLOT_START  = 3'd3,
        ST_PLOT_WAIT   = 3'd4,
        ST_SWAP_WAIT   = 3'd5
    } draw_state_t;

    localparam int c_FB_DATA_WIDTH = 1;

    // A single-pixel buffer still needs one address bit.
    function automatic int addr_width(input int pixels);
        return (pixels > 1) ? $clog2(pixels) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fb_write_mux.sv
// ============================================================================
// Module   : fb_write_mux
// Purpose  : Zero-latency 2:1 framebuffer write-port select; the port is idle
//            (all zero) when neither source is selected.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_write_mux #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 1
) (
    input  logic                  i_sel_a,
    input  logic                  i_sel_b,
    input  logic                  i_a_enable,
    input  logic [ADDR_WIDTH-1:0] i_a_addr,
    input  logic [DATA_WIDTH-1:0] i_a_data,
    input  logic                  i_b_enable,
    input  logic [ADDR_WIDTH-1:0] i_b_addr,
    input  logic [DATA_WIDTH-1:0] i_b_data,
    output logic                  o_enable,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_data
);

    always_comb begin
        o_enable = 1'b0;
        o_addr   = '0;
        o_data   = '0;
        if (i_sel_a) begin
            o_enable = i_a_enable;
            o_addr   = i_a_addr;
            o_data   = i_a_data;
        end else if (i_sel_b) begin
            o_enable = i_b_enable;
            o_addr   = i_b_addr;
            o_data   = i_b_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/draw_scheduler.sv
// ============================================================================
// Module   : draw_scheduler
// Purpose  : Sequences clear, plot and vsync-aligned buffer swap for one frame
//            redraw, owning the single framebuffer write port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module draw_scheduler
    import draw_pkg::*;
#(
    parameter int PIXELS_COUNT      = 640*480,
    parameter int WRITE_DATA_WIDTH  = c_FB_DATA_WIDTH,
    parameter int FRAME_COUNT_WIDTH = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   frame_request,
    input  logic                                   vsync,
    output logic                                   busy,
    output logic                                   clear_start,
    input  logic                                   clear_ready,
    input  logic                                   clear_write_enable,
    input  logic [addr_width(PIXELS_COUNT)-1:0]    clear_write_addr,
    input  logic [WRITE_DATA_WIDTH-1:0]            clear_write_data,
    output logic                                   plot_start,
    input  logic                                   plot_ready,
    input  logic                                   plot_write_enable,
    input  logic [addr_width(PIXELS_COUNT)-1:0]    plot_write_addr,
    input  logic [WRITE_DATA_WIDTH-1:0]            plot_write_data,
    output logic                                   fb_write_enable,
    output logic [addr_width(PIXELS_COUNT)-1:0]    fb_write_addr,
    output logic [WRITE_DATA_WIDTH-1:0]            fb_write_data,
    output logic                                   fb_write_buffer,
    output logic                                   display_buffer,
    output logic [FRAME_COUNT_WIDTH-1:0]           frame_count
);

    localparam int c_AW = addr_width(PIXELS_COUNT);

    draw_state_t                  r_state;
    draw_state_t                  w_next_state;
    logic                         r_display_buffer;
    logic [FRAME_COUNT_WIDTH-1:0] r_frame_count;
    logic                         w_swap;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_display_buffer <= 1'b0;
            r_frame_count    <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_swap) begin
                r_display_buffer <= ~r_display_buffer;
                r_frame_count    <= r_frame_count + {{(FRAME_COUNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    // In the WAIT states a high ready marks the drawer's final write cycle.
    always_comb begin
        w_next_state = r_state;
        clear_start  = 1'b0;
        plot_start   = 1'b0;
        w_swap       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (frame_request) w_next_state = ST_CLEAR_START;
            end
            ST_CLEAR_START: begin
                clear_start = 1'b1;
                if (clear_ready) w_next_state = ST_CLEAR_WAIT;
            end
            ST_CLEAR_WAIT: begin
                if (clear_ready) w_next_state = ST_PLOT_START;
            end
            ST_PLOT_START: begin
                plot_start = 1'b1;
                if (plot_ready) w_next_state = ST_PLOT_WAIT;
            end
            ST_PLOT_WAIT: begin
                if (plot_ready) w_next_state = ST_SWAP_WAIT;
            end
            ST_SWAP_WAIT: begin
                if (vsync) begin
                    w_swap       = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    fb_write_mux #(
        .ADDR_WIDTH (c_AW),
        .DATA_WIDTH (WRITE_DATA_WIDTH)
    ) u_fb_write_mux (
        .i_sel_a    (r_state == ST_CLEAR_WAIT),
        .i_sel_b    (r_state == ST_PLOT_WAIT),
        .i_a_enable (clear_write_enable),
        .i_a_addr   (clear_write_addr),
        .i_a_data   (clear_write_data),
        .i_b_enable (plot_write_enable),
        .i_b_addr   (plot_write_addr),
        .i_b_data   (plot_write_data),
        .o_enable   (fb_write_enable),
        .o_addr     (fb_write_addr),
        .o_data     (fb_write_data)
    );

    assign busy            = (r_state != ST_IDLE);
    assign display_buffer  = r_display_buffer;
    assign fb_write_buffer = ~r_display_buffer;
    assign frame_count     = r_frame_count;

endmodule

`default_nettype wire

// File: tb/tb_draw_scheduler.sv
// ============================================================================
// Module   : tb_draw_scheduler
// Purpose  : Directed bench for draw_scheduler with a 16-pixel fill drawer and
//            a 5-write plot drawer (addresses 3..7).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_draw_scheduler;

    localparam int c_PIX = 16;
    localparam int c_AW  = 4;

    logic             clk;
    logic             rst;
    logic             model_rst;
    logic             frame_request;
    logic             vsync;
    logic             busy;
    logic             clear_start;
    logic             clear_ready;
    logic             clear_write_enable;
    logic [c_AW-1:0]  clear_write_addr;
    logic [0:0]       clear_write_data;
    logic             plot_start;
    logic             plot_ready;
    logic             plot_write_enable;
    logic [c_AW-1:0]  plot_write_addr;
    logic [0:0]       plot_write_data;
    logic             fb_write_enable;
    logic [c_AW-1:0]  fb_write_addr;
    logic [0:0]       fb_write_data;
    logic             fb_write_buffer;
    logic             display_buffer;
    logic [7:0]       frame_count;

    logic             clear_hold;
    logic             plot_leak;
    int               total;
    int               bad;

    draw_scheduler #(
        .PIXELS_COUNT      (c_PIX),
        .WRITE_DATA_WIDTH  (1),
        .FRAME_COUNT_WIDTH (8)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .frame_request      (frame_request),
        .vsync              (vsync),
        .busy               (busy),
        .clear_start        (clear_start),
        .clear_ready        (clear_ready),
        .clear_write_enable (clear_write_enable),
        .clear_write_addr   (clear_write_addr),
        .clear_write_data   (clear_write_data),
        .plot_start         (plot_start),
        .plot_ready         (plot_ready),
        .plot_write_enable  (plot_write_enable),
        .plot_write_addr    (plot_write_addr),
        .plot_write_data    (plot_write_data),
        .fb_write_enable    (fb_write_enable),
        .fb_write_addr      (fb_write_addr),
        .fb_write_data      (fb_write_data),
        .fb_write_buffer    (fb_write_buffer),
        .display_buffer     (display_buffer),
        .frame_count        (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fill drawer: writes 0..15, ready again in its final write cycle.
    logic            f_busy;
    logic [c_AW-1:0] f_addr;
    assign clear_ready        = (!f_busy || f_addr == 4'd15) && !clear_hold;
    assign clear_write_enable = f_busy;
    assign clear_write_addr   = f_addr;
    assign clear_write_data   = 1'b0;

    always @(posedge clk) begin
        if (model_rst) begin
            f_busy <= 1'b0;
            f_addr <= '0;
        end else if (clear_start && clear_ready) begin
            f_busy <= 1'b1;
            f_addr <= '0;
        end else if (f_busy) begin
            if (f_addr == 4'd15) f_busy <= 1'b0;
            else                 f_addr <= f_addr + 4'd1;
        end
    end

    // Plot drawer: writes 3..7 with data 1; plot_leak forces a stray enable.
    logic            p_busy;
    logic [c_AW-1:0] p_addr;
    assign plot_ready        = !p_busy || p_addr == 4'd7;
    assign plot_write_enable = p_busy || plot_leak;
    assign plot_write_addr   = p_addr;
    assign plot_write_data   = 1'b1;

    always @(posedge clk) begin
        if (model_rst) begin
            p_busy <= 1'b0;
            p_addr <= 4'd3;
        end else if (plot_start && plot_ready) begin
            p_busy <= 1'b1;
            p_addr <= 4'd3;
        end else if (p_busy) begin
            if (p_addr == 4'd7) p_busy <= 1'b0;
            else                p_addr <= p_addr + 4'd1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame from IDLE through the swap; ends in IDLE just after the swap.
    task automatic do_frame(input bit hold_req, input int hold_cycles, input int exp_wait,
                            input bit stray, input bit leak, input bit exp_disp,
                            input logic [7:0] exp_cnt);
        int n;
        frame_request = 1'b1;
        clear_hold    = (hold_cycles > 0);
        #1;
        check("idle_busy", busy, 0);
        tick();
        if (!hold_req) frame_request = 1'b0;
        n = 0;
        while (n < 40) begin
            if (n >= hold_cycles) clear_hold = 1'b0;
            #1;
            if (clear_ready === 1'b1) break;
            check("cs_hold_start", clear_start, 1);
            check("cs_hold_we", fb_write_enable, 0);
            tick();
            n++;
        end
        check("cs_wait_cycles", n, exp_wait);
        check("cs_start", clear_start, 1);
        check("cs_busy", busy, 1);
        check("cs_we", fb_write_enable, 0);
        tick();
        for (int i = 0; i < 16; i++) begin
            plot_leak = leak;
            if (stray && i == 5) vsync = 1'b1;
            if (!hold_req && i == 3) frame_request = 1'b1;
            #1;
            check("clr_we", fb_write_enable, 1);
            check("clr_addr", fb_write_addr, i);
            check("clr_data", fb_write_data, 0);
            check("clr_start_low", clear_start, 0);
            check("clr_wbuf", fb_write_buffer, exp_disp);
            tick();
            vsync         = 1'b0;
            frame_request = hold_req;
        end
        plot_leak = 1'b0;
        #1;
        check("ps_start", plot_start, 1);
        check("ps_we", fb_write_enable, 0);
        tick();
        for (int j = 0; j < 5; j++) begin
            if (stray && j == 2) vsync = 1'b1;
            #1;
            check("plot_we", fb_write_enable, 1);
            check("plot_addr", fb_write_addr, 3 + j);
            check("plot_data", fb_write_data, 1);
            tick();
            vsync = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
            check("swap_busy", busy, 1);
            check("swap_we", fb_write_enable, 0);
            check("swap_disp_hold", display_buffer, !exp_disp);
            check("swap_cnt_hold", frame_count, exp_cnt - 8'd1);
            tick();
        end
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        check("swap_disp", display_buffer, exp_disp);
        check("swap_wbuf", fb_write_buffer, !exp_disp);
        check("swap_cnt", frame_count, exp_cnt);
        check("swap_idle", busy, 0);
        if (!hold_req) begin
            tick();
            check("no_queue", busy, 0);
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        model_rst     = 1'b1;
        frame_request = 1'b0;
        vsync         = 1'b0;
        clear_hold    = 1'b0;
        plot_leak     = 1'b0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_we", fb_write_enable, 0);
        check("rst_disp", display_buffer, 0);
        check("rst_wbuf", fb_write_buffer, 1);
        check("rst_cnt", frame_count, 0);
        check("rst_cs", clear_start, 0);
        check("rst_ps", plot_start, 0);
        rst       = 1'b0;
        model_rst = 1'b0;
        tick();

        // Plain frame, then one with not-ready hold, stray vsyncs and leakage.
        do_frame(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 8'd1);
        do_frame(1'b0, 4, 4, 1'b1, 1'b1, 1'b0, 8'd2);

        // Reset while the clear drawer is at address 7.
        frame_request = 1'b1;
        tick();
        frame_request = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            check("mid_addr", fb_write_addr, i);
            if (i < 7) tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_busy", busy, 0);
        check("mid_we", fb_write_enable, 0);
        check("mid_cs", clear_start, 0);
        check("mid_disp", display_buffer, 0);
        check("mid_cnt", frame_count, 0);
        do_frame(1'b0, 0, 6, 1'b0, 1'b0, 1'b1, 8'd1);

        // Continuous request over three frames from a fresh reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        do_frame(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 8'd1);
        do_frame(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 8'd2);
        do_frame(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 8'd3);
        frame_request = 1'b0;
        tick();
        check("cont_idle", busy, 0);
        check("cont_cnt", frame_count, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
